stream_arb_rr: RTL and testbench

- Round-robin arbiter sharing one output stream in the dout_clk domain between NumInputs valid/ready requesters.
- Typical use: merging the outputs of several stream_fifo_2clk instances into one stream_sink or trace path.
- Grants one requester at a time, holds the grant for a burst of up to MaxBurst beats, then rotates.
- Output is registered; tags every beat with the index of its source.

---
 rtl/stream_arb_rr_pkg.sv | 22 ++
 rtl/stream_arb_rr_if.sv | 29 ++
 rtl/stream_arb_rr_rr_pick.sv | 40 ++++
 rtl/stream_arb_rr.sv | 111 +++++++++++
 tb/tb_stream_arb_rr.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_arb_rr_pkg.sv
// Shared definitions for the round-robin stream arbiter: FSM encoding and
// the constant clog2 used to size counters across the stream library.
package stream_arb_rr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_arb_rr_if.sv
// Bundle of the arbiter's requester-side and sink-side stream signals.
// Handshake: a beat moves on a dout_clk edge where valid && ready are both
// high; once valid is raised, data/sel stay stable until that transfer.
// ready never waits on valid, so no combinational loop exists.
interface stream_arb_rr_if #(
  parameter int NumInputs = 4,
  parameter int Width     = 8,
  parameter int SelBits   = 2
);
  logic [NumInputs-1:0]       din_valid;
  logic [NumInputs-1:0]       din_ready;
  logic [NumInputs*Width-1:0] din_data;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [Width-1:0]           dout_data;
  logic [SelBits-1:0]         dout_sel;

  // master: the requesters plus the downstream sink
  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data, dout_sel
  );

  // slave: the arbiter itself
  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data, dout_sel
  );
endinterface

// File: rtl/stream_arb_rr_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo
// NumInputs. Rotate, priority-encode, then un-rotate the found offset.
module rr_pick #(
  parameter int NumInputs = 4,
  parameter int SelBits   = 2
) (
  input  logic [NumInputs-1:0] req,
  input  logic [SelBits-1:0]   ptr,
  output logic                 found,
  output logic [SelBits-1:0]   idx
);
  localparam logic [SelBits:0] NumW = NumInputs[SelBits:0];

  logic [2*NumInputs-1:0] dbl;
  logic [NumInputs-1:0]   rot;
  logic [SelBits-1:0]     off;
  logic [SelBits:0]       sum;
  logic [SelBits:0]       wrapped;

  assign dbl = {req, req};
  assign rot = dbl[ptr +: NumInputs];

  always_comb begin
    found   = 1'b0;
    off     = '0;
    sum     = '0;
    wrapped = '0;
    idx     = '0;
    // Scan downward so the lowest set offset wins.
    for (int i = NumInputs - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i[SelBits-1:0];
      end
    end
    sum     = {1'b0, ptr} + {1'b0, off};
    wrapped = sum - NumW;
    idx     = (sum >= NumW) ? wrapped[SelBits-1:0] : sum[SelBits-1:0];
  end
endmodule

// File: rtl/stream_arb_rr.sv
// Round-robin arbiter merging NumInputs valid/ready streams into one
// registered output stream, tagging each beat with its source index.
module stream_arb_rr
  import stream_arb_rr_pkg::*;
#(
  parameter int NumInputs = 4,
  parameter int Width     = 8,
  parameter int MaxBurst  = 16,
  parameter int SelBits   = 2
) (
  input  logic                  dout_clk,
  input  logic                  rst,
  stream_arb_rr_if.slave        bus,
  output state_t                dbg_state
);
  localparam int                CntBits = clog2(MaxBurst) + 1;
  localparam int                LastI   = MaxBurst - 1;
  localparam int                TopI    = NumInputs - 1;
  localparam logic [CntBits-1:0] CntLast = LastI[CntBits-1:0];
  localparam logic [SelBits-1:0] SelLast = TopI[SelBits-1:0];

  state_t               state;
  logic [SelBits-1:0]   ptr;
  logic [SelBits-1:0]   gsel;
  logic [SelBits-1:0]   ptr_next;
  logic [SelBits-1:0]   pick_idx;
  logic                 pick_found;
  logic [CntBits-1:0]   cnt;
  logic                 acc;
  logic                 xfer;
  logic [Width-1:0]     gdata;
  logic [NumInputs-1:0] din_ready_c;
  logic                 dout_valid_q;
  logic [Width-1:0]     dout_data_q;
  logic [SelBits-1:0]   dout_sel_q;

  rr_pick #(
    .NumInputs (NumInputs),
    .SelBits   (SelBits)
  ) u_pick (
    .req   (bus.din_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The output register can take a beat when empty or being drained.
  assign acc      = !dout_valid_q || bus.dout_ready;
  assign xfer     = (state == GRANT) && acc && bus.din_valid[gsel];
  assign ptr_next = (gsel == SelLast) ? '0 : gsel + SelBits'(1);

  always_comb begin
    din_ready_c = '0;
    if (state == GRANT && acc) din_ready_c[gsel] = 1'b1;
  end

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (gsel == i[SelBits-1:0]) gdata = bus.din_data[i*Width +: Width];
    end
  end

  always_ff @(posedge dout_clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      gsel         <= '0;
      cnt          <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_sel_q   <= '0;
    end else begin
      if (xfer) begin
        dout_valid_q <= 1'b1;
        dout_data_q  <= gdata;
        dout_sel_q   <= gsel;
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            gsel  <= pick_idx;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // While stalled (acc low) the grant is held untouched.
          if (acc) begin
            if (xfer && cnt != CntLast) begin
              cnt <= cnt + CntBits'(1);
            end else begin
              ptr   <= ptr_next;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready  = din_ready_c;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;
  assign bus.dout_sel   = dout_sel_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_stream_arb_rr.sv
// Directed bench for stream_arb_rr: per-requester source queues, an output
// scoreboard and per-cycle traces checked against hand-computed values.
module tb_stream_arb_rr;
  import stream_arb_rr_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;
  localparam int SB = 2;

  // clock / reset
  logic dout_clk = 1'b0;
  logic rst      = 1'b1;
  always #5 dout_clk = ~dout_clk;

  stream_arb_rr_if #(.NumInputs(N), .Width(W), .SelBits(SB)) bus ();
  state_t dbg_state;

  stream_arb_rr #(
    .NumInputs (N),
    .Width     (W),
    .MaxBurst  (MB),
    .SelBits   (SB)
  ) dut (
    .dout_clk  (dout_clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W-1:0]   src_q[N][$];
  logic [SB+W-1:0] exp_q[$];
  int             tr_sel[$];
  int             tr_data[$];
  int             tr_rdy[$];
  logic [N-1:0]   hs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive();
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    d = '0;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        v[i]         = 1'b1;
        d[i*W +: W]  = src_q[i][0];
      end
    end
    bus.din_valid = v;
    bus.din_data  = d;
  endtask

  task automatic push_src(input int i, input int first, input int n);
    for (int k = 0; k < n; k++) src_q[i].push_back(W'(first + k));
  endtask

  task automatic push_exp(input int sel, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({SB'(sel), W'(first + k)});
  endtask

  // scoreboard / trace capture, sampled mid-cycle
  task automatic monitor();
    tr_sel.push_back(bus.dout_valid ? int'(bus.dout_sel) : -1);
    tr_data.push_back(int'(bus.dout_data));
    tr_rdy.push_back(int'(bus.din_ready));
    hs = rst ? '0 : (bus.din_valid & bus.din_ready);
    if (!rst && bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", exp_q.size(), 1);
      end else begin
        check("sb_beat", {bus.dout_sel, bus.dout_data}, exp_q[0]);
        if (bus.dout_ready) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic cycle();
    @(negedge dout_clk);
    monitor();
    @(posedge dout_clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic clear_traces();
    tr_sel.delete();
    tr_data.delete();
    tr_rdy.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    bus.dout_ready = 1'b1;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    clear_traces();
  endtask

  function automatic int count_valid();
    int c = 0;
    foreach (tr_sel[k]) if (tr_sel[k] >= 0) c++;
    return c;
  endfunction

  initial begin
    bus.din_valid  = '0;
    bus.din_data   = '0;
    bus.dout_ready = 1'b1;

    // reset state
    do_reset();
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout_data", bus.dout_data, 0);
    check("rst_dout_sel", bus.dout_sel, 0);
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_state", dbg_state, IDLE);

    // single requester, 32 beats, rotation bubble after beat 16
    do_reset();
    push_src(2, 8'h10, 32);
    push_exp(2, 8'h10, 32);
    drive();
    repeat (38) cycle();
    check("t1_latency_gap", tr_sel[1], -1);
    check("t1_first_sel", tr_sel[2], 2);
    check("t1_first_data", tr_data[2], 8'h10);
    check("t1_beat16", tr_sel[17], 2);
    check("t1_bubble", tr_sel[18], -1);
    check("t1_beat17", tr_sel[19], 2);
    check("t1_beat17_data", tr_data[19], 8'h20);
    check("t1_tail_idle", tr_sel[35], -1);
    check("t1_count", count_valid(), 32);
    check("t1_drain", exp_q.size(), 0);

    // all four valid: groups of sixteen, rotating 0,1,2,3,0
    do_reset();
    push_src(0, 0, 20);
    for (int i = 1; i < N; i++) push_src(i, i * 32, 16);
    push_exp(0, 0, 16);
    push_exp(1, 32, 16);
    push_exp(2, 64, 16);
    push_exp(3, 96, 16);
    push_exp(0, 16, 4);
    drive();
    repeat (80) cycle();
    check("t2_g0_end", tr_sel[17], 0);
    check("t2_bub0", tr_sel[18], -1);
    check("t2_g1", tr_sel[19], 1);
    check("t2_bub1", tr_sel[35], -1);
    check("t2_g2", tr_sel[36], 2);
    check("t2_bub2", tr_sel[52], -1);
    check("t2_g3", tr_sel[53], 3);
    check("t2_bub3", tr_sel[69], -1);
    check("t2_g0_again", tr_sel[70], 0);
    check("t2_count", count_valid(), 68);
    check("t2_drain", exp_q.size(), 0);

    // early release, then requester 0 revalidates while ptr=1
    do_reset();
    push_src(0, 8'hA0, 3);
    push_src(1, 8'hB0, 5);
    push_exp(0, 8'hA0, 3);
    push_exp(1, 8'hB0, 5);
    push_exp(0, 8'hC0, 2);
    drive();
    repeat (5) cycle();
    push_src(0, 8'hC0, 2);
    drive();
    repeat (15) cycle();
    check("t3_last0", tr_sel[4], 0);
    check("t3_gap_a", tr_sel[5], -1);
    check("t3_gap_b", tr_sel[6], -1);
    check("t3_first1", tr_sel[7], 1);
    check("t3_last1", tr_sel[11], 1);
    check("t3_gap_c", tr_sel[13], -1);
    check("t3_back0", tr_sel[14], 0);
    check("t3_drain", exp_q.size(), 0);

    // backpressure: dout_ready 1,0,0,1 mid-burst
    do_reset();
    push_src(1, 8'h50, 6);
    push_exp(1, 8'h50, 6);
    drive();
    for (int k = 1; k <= 14; k++) begin
      cycle();
      bus.dout_ready = (k == 3 || k == 4) ? 1'b0 : 1'b1;
    end
    check("t4_rdy_pre", tr_rdy[2], 4'b0010);
    check("t4_rdy_stall_a", tr_rdy[3], 0);
    check("t4_rdy_stall_b", tr_rdy[4], 0);
    check("t4_rdy_resume", tr_rdy[5], 4'b0010);
    check("t4_hold_a", tr_data[3], 8'h51);
    check("t4_hold_b", tr_data[4], 8'h51);
    check("t4_hold_c", tr_data[5], 8'h51);
    check("t4_next", tr_data[6], 8'h52);
    check("t4_last_data", tr_data[9], 8'h55);
    check("t4_end_idle", tr_sel[10], -1);
    check("t4_drain", exp_q.size(), 0);

    // pointer wrap: after 3 releases, 0 wins over 3
    do_reset();
    push_src(3, 8'h30, 2);
    push_exp(3, 8'h30, 2);
    push_exp(0, 8'h40, 1);
    push_exp(3, 8'h32, 1);
    drive();
    repeat (4) cycle();
    push_src(0, 8'h40, 1);
    push_src(3, 8'h32, 1);
    drive();
    repeat (8) cycle();
    check("t5_sel3", tr_sel[3], 3);
    check("t5_wrap0", tr_sel[6], 0);
    check("t5_then3", tr_sel[9], 3);
    check("t5_drain", exp_q.size(), 0);

    // reset mid-burst with a held output beat
    do_reset();
    push_src(2, 8'h60, 1);
    push_src(3, 8'h70, 10);
    push_exp(2, 8'h60, 1);
    push_exp(3, 8'h70, 1);
    drive();
    repeat (6) cycle();
    check("t6_pre_valid", bus.dout_valid, 1);
    rst = 1'b1;
    cycle();
    check("t6_rst_valid", bus.dout_valid, 0);
    check("t6_rst_ready", bus.din_ready, 0);
    check("t6_rst_sel", bus.dout_sel, 0);
    check("t6_rst_data", bus.dout_data, 0);
    check("t6_rst_state", dbg_state, IDLE);
    rst = 1'b0;
    push_src(0, 8'h80, 1);
    push_exp(0, 8'h80, 1);
    push_exp(3, 8'h72, 8);
    drive();
    repeat (14) cycle();
    check("t6_pre_sel3", tr_sel[5], 3);
    check("t6_post_idle", tr_sel[7], -1);
    check("t6_restart0", tr_sel[9], 0);
    check("t6_restart0_data", tr_data[9], 8'h80);
    check("t6_resume3", tr_sel[12], 3);
    check("t6_drain", exp_q.size(), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
